// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: time-multiplexed 4-digit 7-segment driver (HH:MM) with a tear-free input snapshot.
// Optional feature macro LEADING_ZERO_BLANK_EN: keep the hour-tens digit dark when it is 0.
module seg7_scan_drv #(
    parameter int SCAN_DIV = 32,
    parameter int DEAD     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] digits_i,
    input  logic        colon_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    idx_reg, idx_next;
    logic [16:0]   raw_reg;
    logic [15:0]   snap_reg, snap_next;
    logic          colon_snap_reg, colon_snap_next;
    logic          pending_reg, pending_next;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    logic [16:0]   in_vec;
    logic          in_stable;
    logic          cnt_wrap;
    logic          frame_end;
    logic          dead_win;
    logic [3:0]    snap_digit [4];
    logic [3:0]    cur_digit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign snap_digit[gi] = snap_reg[4*gi +: 4];
        end
    endgenerate

    assign in_vec    = {colon_i, digits_i};
    assign in_stable = (in_vec == raw_reg);
    assign cnt_wrap  = (cnt_reg == CNT_MAX);
    assign frame_end = cnt_wrap && (idx_reg == 2'd3);
    assign dead_win  = (int'(cnt_reg) < DEAD);
    assign cur_digit = snap_digit[idx_reg];

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_next = cnt_wrap ? '0 : cnt_reg + 1'b1;
        idx_next = cnt_wrap ? idx_reg + 2'd1 : idx_reg;
    end

    // Snapshot only ever changes between frames or inside digit 0's blank window,
    // so no lit slot can show a half-updated value.
    always_comb begin
        snap_next       = snap_reg;
        colon_snap_next = colon_snap_reg;
        pending_next    = pending_reg;
        if (frame_end) begin
            if (in_stable) begin
                snap_next       = digits_i;
                colon_snap_next = colon_i;
                pending_next    = 1'b0;
            end else begin
                pending_next    = 1'b1;
            end
        end else if (pending_reg) begin
            if (dead_win && (idx_reg == 2'd0)) begin
                if (in_stable) begin
                    snap_next       = digits_i;
                    colon_snap_next = colon_i;
                    pending_next    = 1'b0;
                end
            end else begin
                pending_next = 1'b0;
            end
        end
    end

    always_comb begin
        an_next  = '0;
        seg_next = '0;
        dp_next  = 1'b0;
        if (!dead_win) begin
            an_next  = 4'b0001 << idx_reg;
            seg_next = seg_decode(cur_digit);
            dp_next  = (idx_reg == 2'd1) && colon_snap_reg;
`ifdef LEADING_ZERO_BLANK_EN
            if ((idx_reg == 2'd3) && (snap_digit[3] == 4'd0)) begin
                an_next  = '0;
                seg_next = '0;
            end
`endif
        end
    end

    // pending starts set so the first frame after reset picks up the inputs
    // as soon as they have been stable for one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            raw_reg        <= '0;
            snap_reg       <= '0;
            colon_snap_reg <= 1'b0;
            pending_reg    <= 1'b1;
            an_o           <= '0;
            seg_o          <= '0;
            dp_o           <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            raw_reg        <= in_vec;
            snap_reg       <= snap_next;
            colon_snap_reg <= colon_snap_next;
            pending_reg    <= pending_next;
            an_o           <= an_next;
            seg_o          <= seg_next;
            dp_o           <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Table-driven bench for seg7_scan_drv with a per-slot scoreboard keyed by frame number.
module tb_seg7_scan_drv;
    localparam int SD = 8;
    localparam int DD = 2;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_i = '0;
    logic        colon_i = 1'b0;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    seg7_scan_drv #(.SCAN_DIV(SD), .DEAD(DD)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .digits_i (digits_i),
        .colon_i  (colon_i),
        .an_o     (an_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o)
    );

    always #5 clk = ~clk;

    int edge_n;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    typedef struct {
        logic [15:0]     digits;
        logic            colon;
        logic [3:0][6:0] seg;
    } vec_t;

    typedef struct {
        int         frame;
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[6];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
        end
    endtask

    function automatic void push_frame(input vec_t r, input int f);
        sb_t e;
        for (int s = 0; s < 4; s++) begin
            e.frame = f;
            e.slot  = s;
            e.an    = 4'b0001 << s;
            e.seg   = r.seg[s];
            e.dp    = (s == 1) ? r.colon : 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (s == 3 && r.digits[15:12] == 4'd0) begin
                e.an  = '0;
                e.seg = '0;
            end
`endif
            sb.push_back(e);
        end
    endfunction

    // One clock; checks the outputs at the falling edge against timing and scoreboard.
    task automatic tick();
        int  k, c, i, f;
        sb_t e;
        @(negedge clk);
        if (rst || edge_n == 0) return;
        k = edge_n - 1;
        c = k % SD;
        i = (k / SD) % 4;
        f = k / FR;
        if (c < DD) begin
            chk("dead_blank", {20'h0, an_o, seg_o, dp_o}, 32'h0);
        end else begin
            while (sb.size() > 0 && (sb[0].frame < f || (sb[0].frame == f && sb[0].slot < i))) begin
                chk("sb_stale_slot", sb[0].frame * 4 + sb[0].slot, f * 4 + i);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].frame == f && sb[0].slot == i) begin
                e = sb[0];
                chk("slot_out", {20'h0, an_o, seg_o, dp_o}, {20'h0, e.an, e.seg, e.dp});
                if (c == SD - 1) void'(sb.pop_front());
            end else begin
`ifdef LEADING_ZERO_BLANK_EN
                if (i != 3) chk("an_onehot", {28'h0, an_o}, {28'h0, 4'b0001 << i});
`else
                chk("an_onehot", {28'h0, an_o}, {28'h0, 4'b0001 << i});
`endif
            end
        end
    endtask

    task automatic wait_pos(input int f, input int p);
        int n = 0;
        while (!(edge_n > 0 && (edge_n - 1) / FR == f && (edge_n - 1) % FR == p) && n < 4000) begin
            tick();
            n++;
        end
        if (n >= 4000) chk("wait_pos_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        vec_t r0, s_last, x_fin;
        int   next_frame;
        int   n;

        r0 = '{16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
        tbl[0] = '{16'h1235, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h6D}};
        tbl[1] = '{16'h0959, 1'b1, {7'h3F, 7'h6F, 7'h6D, 7'h6F}};
        tbl[2] = '{16'hFA00, 1'b0, {7'h40, 7'h40, 7'h3F, 7'h3F}};
        tbl[3] = '{16'h8876, 1'b1, {7'h7F, 7'h7F, 7'h07, 7'h7D}};
        tbl[4] = '{16'h0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        tbl[5] = '{16'hBCDE, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}};

        // Reset with 1234 already on the inputs; frames 0 and 1 must show it.
        digits_i = r0.digits;
        colon_i  = r0.colon;
        repeat (3) tick();
        chk("reset_state", {20'h0, an_o, seg_o, dp_o}, 32'h0);
        push_frame(r0, 0);
        push_frame(r0, 1);
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (an_o == 4'b0000 && n < 50);
        chk("first_lit_edge", 32'(n), 32'd3);
        $display("vec startup digits=%h colon=%b frames 0-1", r0.digits, r0.colon);

        // Each vector changes mid-frame: the current frame keeps the old value.
        next_frame = 1;
        s_last = r0;
        for (int v = 0; v < 6; v++) begin
            wait_pos(next_frame, 3);
            digits_i = tbl[v].digits;
            colon_i  = tbl[v].colon;
            push_frame(tbl[v], next_frame + 1);
            push_frame(tbl[v], next_frame + 2);
            $display("vec %0d digits=%h colon=%b frames %0d-%0d", v, tbl[v].digits, tbl[v].colon,
                     next_frame + 1, next_frame + 2);
            next_frame += 2;
            s_last = tbl[v];
        end

        // Inputs toggle every cycle across the frame boundary and digit 0's blank window.
        wait_pos(next_frame, 28);
        for (int t = 0; t < 8; t++) begin
            digits_i = t[0] ? 16'h5555 : 16'h2222;
            tick();
        end
        x_fin = '{16'h5555, s_last.colon, {7'h6D, 7'h6D, 7'h6D, 7'h6D}};
        push_frame(s_last, next_frame + 1);
        push_frame(x_fin, next_frame + 2);
        $display("vec toggle held=%h then %h frames %0d-%0d", s_last.digits, x_fin.digits,
                 next_frame + 1, next_frame + 2);
        next_frame += 2;
        wait_pos(next_frame + 1, 0);
        chk("sb_drained_pre_reset", 32'(sb.size()), 32'd0);

        // Asynchronous reset while digit 2 is lit.
        n = 0;
        while (an_o != 4'b0100 && n < 200) begin
            tick();
            n++;
        end
        chk("found_digit2", {28'h0, an_o}, 32'h4);
        #2 rst = 1'b1;
        #1 chk("async_reset_blank", {20'h0, an_o, seg_o, dp_o}, 32'h0);
        sb.delete();
        digits_i = tbl[2].digits;
        colon_i  = tbl[2].colon;
        repeat (3) tick();
        push_frame(tbl[2], 0);
        push_frame(tbl[2], 1);
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (an_o == 4'b0000 && n < 50);
        chk("post_reset_lit_edge", 32'(n), 32'd3);
        chk("post_reset_an", {28'h0, an_o}, 32'h1);
        $display("vec post_reset digits=%h colon=%b frames 0-1", tbl[2].digits, tbl[2].colon);
        wait_pos(2, 0);
        chk("sb_drained_end", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
